gray_position_sequencer: RTL and testbench

//  Move controller for an external Gray-code up/down counter with step enable.

---
 rtl/gray_pkg.sv | 29 ++
 rtl/gray_position_sequencer.sv | 130 +++++++++++++
 tb/tb_gray_position_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared helpers and state encoding for the Gray-code position sequencer.
// Gray/binary conversions work on a wide word; callers zero-extend and slice.
package gray_pkg;

    localparam int MAXW = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECIDE = 3'd1,
        STEP   = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4,
        FAULT  = 3'd5
    } state_t;

    function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
        logic [MAXW-1:0] b;
        b[MAXW-1] = g[MAXW-1];
        for (int i = MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_position_sequencer.sv
// Drives an external Gray up/down counter toward a binary target,
// verifying every step lands as the single expected Gray transition.
module gray_position_sequencer
    import gray_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int STEP_GAP = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] gray_in,
    output logic             cnt_en,
    output logic             cnt_dir,
    output logic [WIDTH-1:0] pos_bin,
    output logic             busy,
    output logic             done,
    output logic             fault
);

    localparam int GW = $clog2(STEP_GAP + 1);

    state_t           state_q, state_n;
    logic [WIDTH-1:0] tgt_q, tgt_n;
    logic [WIDTH-1:0] exp_q, exp_n;
    logic             first_q, first_n;
    logic             dir_q, dir_n;
    logic [GW-1:0]    gap_q, gap_n;

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] up;
    logic [WIDTH-1:0] dn;
    logic [WIDTH-1:0] nxt;
    logic             step_up;

    // Next-state and datapath decisions; registered outputs follow state_n.
    always_comb begin
        state_n = state_q;
        tgt_n   = tgt_q;
        exp_n   = exp_q;
        first_n = first_q;
        dir_n   = dir_q;
        gap_n   = gap_q;
        p       = WIDTH'(gray2bin(MAXW'(gray_in)));
        up      = tgt_q - p;
        dn      = p - tgt_q;
        step_up = (up <= dn);
        nxt     = step_up ? p + WIDTH'(1) : p - WIDTH'(1);
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    tgt_n   = target;
                    first_n = 1'b1;
                    state_n = DECIDE;
                end
            end
            DECIDE: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (!first_q && gray_in != exp_q) begin
                    state_n = FAULT;
                end else if (p == tgt_q) begin
                    state_n = DONE;
                end else begin
                    dir_n   = step_up;
                    exp_n   = WIDTH'(bin2gray(MAXW'(nxt)));
                    first_n = 1'b0;
                    state_n = STEP;
                end
            end
            STEP: begin
                gap_n   = '0;
                state_n = abort ? IDLE : WAIT;
            end
            WAIT: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (gap_q == GW'(STEP_GAP - 1)) begin
                    state_n = DECIDE;
                end else begin
                    gap_n = gap_q + GW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            FAULT: begin
                if (abort) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, latched move context and Moore output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            exp_q   <= '0;
            first_q <= 1'b0;
            dir_q   <= 1'b0;
            gap_q   <= '0;
            cnt_en  <= 1'b0;
            cnt_dir <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            fault   <= 1'b0;
            pos_bin <= '0;
        end else begin
            state_q <= state_n;
            tgt_q   <= tgt_n;
            exp_q   <= exp_n;
            first_q <= first_n;
            dir_q   <= dir_n;
            gap_q   <= gap_n;
            cnt_en  <= (state_n == STEP);
            cnt_dir <= dir_n;
            busy    <= (state_n == DECIDE) || (state_n == STEP)
                    || (state_n == WAIT);
            done    <= (state_n == DONE);
            fault   <= (state_n == FAULT);
            pos_bin <= p;
        end
    end

endmodule

// File: tb/tb_gray_position_sequencer.sv
// Directed bench: a Gray up/down counter model closes the loop around
// the sequencer; move vectors come from a table, corner cases by hand.
module tb_gray_position_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] target = 4'd0;
    logic [3:0] gray_in;
    logic       cnt_en;
    logic       cnt_dir;
    logic [3:0] pos_bin;
    logic       busy;
    logic       done;
    logic       fault;

    logic       load_req = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       drop_en = 1'b0;
    logic [3:0] b = 4'd0;
    int         pcount = 0;

    int checks = 0;
    int failures = 0;
    int gtrace[16];
    int ntr;

    typedef struct {
        int pos;
        int tgt;
        int steps;
        int up;
        int kdone;
    } vec_t;

    vec_t vecs[7];

    gray_position_sequencer #(.WIDTH(4), .STEP_GAP(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .target(target),
        .gray_in(gray_in),
        .cnt_en(cnt_en),
        .cnt_dir(cnt_dir),
        .pos_bin(pos_bin),
        .busy(busy),
        .done(done),
        .fault(fault)
    );

    always #5 clk = ~clk;

    assign gray_in = b ^ (b >> 1);

    // External counter model: load port, optional dropped second pulse.
    always @(posedge clk) begin
        if (load_req) begin
            b      <= load_val;
            pcount <= 0;
        end else if (cnt_en) begin
            pcount <= pcount + 1;
            if (!(drop_en && pcount == 1)) begin
                b <= cnt_dir ? b + 4'd1 : b - 4'd1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic load_pos(input int v, input logic drop);
        @(negedge clk);
        load_val = 4'(v);
        load_req = 1'b1;
        drop_en  = drop;
        @(negedge clk);
        load_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic launch(input int tgt);
        start  = 1'b1;
        target = 4'(tgt);
    endtask

    task automatic watch(input int budget, input int inj_k,
                         output int kdone, output int npulse,
                         output int nup);
        logic pend;
        pend   = 1'b0;
        kdone  = -1;
        npulse = 0;
        nup    = 0;
        ntr    = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start  = 1'b0;
                target = ~target;
            end
            if (k == inj_k) begin
                start  = 1'b1;
                target = 4'd9;
            end
            if (k == inj_k + 1) start = 1'b0;
            if (pend) begin
                if (ntr < 16) gtrace[ntr] = int'(gray_in);
                ntr++;
                pend = 1'b0;
            end
            if (cnt_en) begin
                npulse++;
                if (cnt_dir) nup++;
                pend = 1'b1;
            end
            if (done) begin
                kdone = k;
                break;
            end
        end
    endtask

    initial begin
        int kd, np, nu, kf, acc;
        int g0[5];
        int g1[3];
        g0 = '{1, 3, 2, 6, 7};
        g1 = '{8, 0, 1};
        vecs[0] = '{0, 5, 5, 1, 22};
        vecs[1] = '{14, 1, 3, 1, 14};
        vecs[2] = '{5, 2, 3, 0, 14};
        vecs[3] = '{3, 11, 8, 1, 34};
        vecs[4] = '{7, 7, 0, 1, 2};
        vecs[5] = '{1, 15, 2, 0, 10};
        vecs[6] = '{9, 13, 4, 1, 18};

        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({cnt_en, cnt_dir, busy, done, fault, pos_bin}), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            load_pos(vecs[i].pos, 1'b0);
            chk($sformatf("v%0d_pos_readback", i), int'(pos_bin), vecs[i].pos);
            launch(vecs[i].tgt);
            watch(60, -10, kd, np, nu);
            chk($sformatf("v%0d_done_cycle", i), kd, vecs[i].kdone);
            chk($sformatf("v%0d_pulses", i), np, vecs[i].steps);
            chk($sformatf("v%0d_up_pulses", i), nu, vecs[i].up * vecs[i].steps);
            chk($sformatf("v%0d_final_pos", i), int'(pos_bin), vecs[i].tgt);
            @(negedge clk);
            chk($sformatf("v%0d_done_one_cycle", i), int'({done, busy}), 0);
            if (i == 0) begin
                for (int j = 0; j < 5; j++)
                    chk($sformatf("v0_gray%0d", j), gtrace[j], g0[j]);
            end
            if (i == 1) begin
                for (int j = 0; j < 3; j++)
                    chk($sformatf("v1_gray%0d", j), gtrace[j], g1[j]);
            end
        end

        // start while busy and target change are ignored
        load_pos(0, 1'b0);
        launch(2);
        watch(40, 3, kd, np, nu);
        chk("busy_start_done_cycle", kd, 10);
        chk("busy_start_final_pos", int'(pos_bin), 2);
        @(negedge clk);
        chk("busy_start_no_restart", int'({busy, cnt_en}), 0);

        // abort while the step pulse is on the counter
        load_pos(0, 1'b0);
        launch(5);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_step_pulse_seen", int'(cnt_en), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", int'({busy, cnt_en}), 0);
        acc = 0;
        repeat (5) begin
            @(negedge clk);
            acc = acc | int'({done, busy, cnt_en});
        end
        chk("abort_no_done", acc, 0);
        chk("abort_step_landed", int'(pos_bin), 1);

        // start and abort together stay idle
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        target = 4'd6;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        acc = 0;
        repeat (4) begin
            @(negedge clk);
            acc = acc | int'({done, busy, cnt_en});
        end
        chk("start_abort_idle", acc, 0);

        // dropped second pulse raises a sticky fault
        load_pos(0, 1'b1);
        launch(5);
        kf = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (fault) begin
                kf = k;
                break;
            end
        end
        chk("fault_cycle", kf, 10);
        chk("fault_busy_low", int'(busy), 0);
        start = 1'b1;
        target = 4'd3;
        @(negedge clk);
        start = 1'b0;
        acc = 0;
        repeat (4) begin
            @(negedge clk);
            acc = acc | int'({busy, cnt_en, done});
        end
        chk("fault_start_ignored", acc, 0);
        chk("fault_sticky", int'(fault), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("fault_cleared", int'(fault), 0);
        load_pos(0, 1'b0);

        // asynchronous reset mid-step
        launch(5);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rst_pre_pulse", int'(cnt_en), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", int'({cnt_en, busy, done, fault, pos_bin}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        acc = 0;
        repeat (4) begin
            @(negedge clk);
            acc = acc | int'({busy, cnt_en, done});
        end
        chk("rst_release_idle", acc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
